// File: rtl/gnr_node_mr.sv
// Multi-rate gene-regulatory-network node.
// Holds one state register per time-scale channel. Each channel loads the
// network's next-state value on its update strobe, thinned by a per-channel
// divider. A stability detector counts consecutive update events that left
// every updating channel unchanged.
module gnr_node_mr #(
  parameter int W        = 1,
  parameter int NCH      = 2,
  parameter int DIVW     = 4,
  parameter int STABLE_N = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                reset_nos,
  input  logic [NCH-1:0]      start_s,
  input  logic [W-1:0]        init_state,
  input  logic [NCH*DIVW-1:0] div_cfg,
  input  logic [NCH*W-1:0]    crk_s,
  output logic [NCH*W-1:0]    s,
  output logic [NCH-1:0]      upd,
  output logic [NCH-1:0]      chg,
  output logic                stable
);

  localparam logic [8:0] STAB_LIM = 9'(STABLE_N);

  logic [NCH*W-1:0]    s_q, s_d;
  logic [NCH*DIVW-1:0] div_q, div_d;
  logic [NCH*DIVW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]      upd_q, upd_d;
  logic [NCH-1:0]      chg_q, chg_d;
  logic [7:0]          sc_q, sc_d;
  logic                stable_q, stable_d;

  logic                any_load;
  logic                any_diff;
  logic [8:0]          sc_inc;

  // Next-state: reinit, per-channel load/skip, and stability tracking.
  always_comb begin
    s_d      = s_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    upd_d    = '0;
    chg_d    = '0;
    sc_d     = sc_q;
    stable_d = stable_q;
    any_load = 1'b0;
    any_diff = 1'b0;
    sc_inc   = {1'b0, sc_q} + 9'd1;
    if (reset_nos) begin
      // Strobes arriving with a reinit are dropped on purpose.
      s_d      = {NCH{init_state}};
      div_d    = div_cfg;
      cnt_d    = '0;
      sc_d     = '0;
      stable_d = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (start && start_s[i]) begin
          if (cnt_q[i*DIVW +: DIVW] == '0) begin
            // Load from the network and rearm the skip counter.
            s_d[i*W +: W]      = crk_s[i*W +: W];
            cnt_d[i*DIVW +: DIVW] = div_q[i*DIVW +: DIVW];
            upd_d[i]           = 1'b1;
            chg_d[i]           = (crk_s[i*W +: W] != s_q[i*W +: W]);
            any_load           = 1'b1;
            if (crk_s[i*W +: W] != s_q[i*W +: W]) any_diff = 1'b1;
          end else begin
            cnt_d[i*DIVW +: DIVW] = cnt_q[i*DIVW +: DIVW] - 1'b1;
          end
        end
      end
      // Simultaneous channel loads count as one update event.
      if (any_load) begin
        if (any_diff) begin
          sc_d     = '0;
          stable_d = 1'b0;
        end else begin
          sc_d     = (sc_inc >= STAB_LIM) ? STAB_LIM[7:0] : sc_inc[7:0];
          stable_d = (sc_inc >= STAB_LIM);
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      upd_q    <= '0;
      chg_q    <= '0;
      sc_q     <= '0;
      stable_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      upd_q    <= upd_d;
      chg_q    <= chg_d;
      sc_q     <= sc_d;
      stable_q <= stable_d;
    end
  end

  assign s      = s_q;
  assign upd    = upd_q;
  assign chg    = chg_q;
  assign stable = stable_q;

endmodule

// File: tb/tb_gnr_node_mr.sv
// Testbench for gnr_node_mr: table-driven directed vectors, hand-written
// corner sequences and a randomized run against a strobe-counting model.
module tb_gnr_node_mr;

  localparam int W    = 4;
  localparam int NCH  = 4;
  localparam int DIVW = 4;
  localparam int SN   = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic                reset_nos;
  logic [NCH-1:0]      start_s;
  logic [W-1:0]        init_state;
  logic [NCH*DIVW-1:0] div_cfg;
  logic [NCH*W-1:0]    crk_s;
  logic [NCH*W-1:0]    s;
  logic [NCH-1:0]      upd;
  logic [NCH-1:0]      chg;
  logic                stable;

  gnr_node_mr #(.W(W), .NCH(NCH), .DIVW(DIVW), .STABLE_N(SN)) dut (
    .clk(clk), .rst(rst), .start(start), .reset_nos(reset_nos),
    .start_s(start_s), .init_state(init_state), .div_cfg(div_cfg),
    .crk_s(crk_s), .s(s), .upd(upd), .chg(chg), .stable(stable)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: a channel updates on accepted strobes number
  // 0, div+1, 2*(div+1), ... counted since the last reinit.
  logic [W-1:0] m_s   [NCH];
  int           m_div [NCH];
  int           m_acc [NCH];
  int           m_run;
  logic [NCH-1:0] m_upd, m_chg;
  logic         m_stable;

  function automatic logic [NCH*W-1:0] m_svec();
    logic [NCH*W-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*W +: W] = m_s[i];
    return v;
  endfunction

  task automatic model_update();
    bit ev, ch;
    m_upd = '0;
    m_chg = '0;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_s[i] = '0; m_div[i] = 0; m_acc[i] = 0;
      end
      m_run = 0; m_stable = 1'b0;
    end else if (reset_nos) begin
      for (int i = 0; i < NCH; i++) begin
        m_s[i] = init_state; m_div[i] = int'(div_cfg[i*DIVW +: DIVW]); m_acc[i] = 0;
      end
      m_run = 0; m_stable = 1'b0;
    end else begin
      ev = 0; ch = 0;
      for (int i = 0; i < NCH; i++) begin
        if (start && start_s[i]) begin
          if (m_acc[i] % (m_div[i] + 1) == 0) begin
            m_upd[i] = 1'b1;
            m_chg[i] = (crk_s[i*W +: W] != m_s[i]);
            if (m_chg[i]) ch = 1;
            m_s[i] = crk_s[i*W +: W];
            ev = 1;
          end
          m_acc[i]++;
        end
      end
      if (ev) begin
        if (ch) m_run = 0;
        else    m_run++;
        m_stable = (m_run >= SN);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the same edge, outputs checked 1ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    chk({tag, ".s"},      32'(s),      32'(m_svec()));
    chk({tag, ".upd"},    32'(upd),    32'(m_upd));
    chk({tag, ".chg"},    32'(chg),    32'(m_chg));
    chk({tag, ".stable"}, 32'(stable), 32'(m_stable));
  endtask

  task automatic idle();
    rst = 0; reset_nos = 0; start = 1; start_s = '0;
  endtask

  typedef struct {
    logic             start;
    logic [NCH-1:0]   stb;
    logic [NCH*W-1:0] crk;
    logic [NCH*W-1:0] exp_s;
    logic [NCH-1:0]   exp_upd;
    logic [NCH-1:0]   exp_chg;
  } vec_t;

  vec_t tbl [7];
  int   ucnt [NCH];

  initial begin
    rst = 1; reset_nos = 0; start = 0; start_s = '0;
    init_state = '0; div_cfg = '0; crk_s = '0;
    for (int i = 0; i < NCH; i++) begin
      m_s[i] = '0; m_div[i] = 0; m_acc[i] = 0;
    end
    m_run = 0; m_stable = 0; m_upd = '0; m_chg = '0;

    // Reset state, then reinit to a known value.
    step("rst0");
    step("rst1");
    chk("rst.s", 32'(s), 32'h0);
    chk("rst.stable", 32'(stable), 32'h0);
    rst = 0; reset_nos = 1; init_state = 4'h5;
    step("init");
    chk("init.s", 32'(s), 32'h5555);
    chk("init.upd", 32'(upd), 32'h0);

    // Directed table, divider ch_i = i, state starts at 0.
    tbl[0] = '{1'b1, 4'hF, 16'h1111, 16'h1111, 4'b1111, 4'b1111};
    tbl[1] = '{1'b1, 4'hF, 16'h0000, 16'h1110, 4'b0001, 4'b0001};
    tbl[2] = '{1'b1, 4'hF, 16'h1111, 16'h1111, 4'b0011, 4'b0001};
    tbl[3] = '{1'b1, 4'hF, 16'h0000, 16'h1010, 4'b0101, 4'b0101};
    tbl[4] = '{1'b0, 4'hF, 16'h1111, 16'h1010, 4'b0000, 4'b0000};
    tbl[5] = '{1'b1, 4'h0, 16'h1111, 16'h1010, 4'b0000, 4'b0000};
    tbl[6] = '{1'b1, 4'hF, 16'h0000, 16'h0000, 4'b1011, 4'b1010};
    reset_nos = 1; init_state = 4'h0; div_cfg = 16'h3210; start_s = 4'hF; start = 1;
    crk_s = 16'hFFFF;
    step("tbl.init");
    chk("strobe_with_reinit.upd", 32'(upd), 32'h0);
    chk("strobe_with_reinit.s", 32'(s), 32'h0);
    reset_nos = 0;
    for (int k = 0; k < 7; k++) begin
      start = tbl[k].start; start_s = tbl[k].stb; crk_s = tbl[k].crk;
      div_cfg = 16'hFFFF;  // ignored between reinits
      step($sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.s_vec", k),   32'(s),   32'(tbl[k].exp_s));
      chk($sformatf("tbl%0d.upd_vec", k), 32'(upd), 32'(tbl[k].exp_upd));
      chk($sformatf("tbl%0d.chg_vec", k), 32'(chg), 32'(tbl[k].exp_chg));
      chk($sformatf("tbl%0d.stable_vec", k), 32'(stable), 32'h0);
    end

    // Stability: three changeless events assert stable, a change clears it.
    idle(); reset_nos = 1; init_state = 4'h5; div_cfg = 16'h0000;
    step("stab.init");
    reset_nos = 0; crk_s = 16'h5555;
    for (int k = 1; k <= 3; k++) begin
      start_s = 4'h1;
      step($sformatf("stab%0d", k));
      chk($sformatf("stab%0d.stable_vec", k), 32'(stable), (k >= 3) ? 32'h1 : 32'h0);
      start_s = '0;
      step($sformatf("stab%0d.gap", k));
    end
    chk("stab.hold", 32'(stable), 32'h1);
    crk_s = 16'h5556; start_s = 4'h3;
    step("stab.break");
    chk("stab.break.chg", 32'(chg), 32'h1);
    chk("stab.break.stable", 32'(stable), 32'h0);

    // Multi-rate counts over 12 held strobes.
    idle(); reset_nos = 1; init_state = 4'h0; div_cfg = 16'h3210;
    step("rate.init");
    reset_nos = 0; start_s = 4'hF;
    for (int i = 0; i < NCH; i++) ucnt[i] = 0;
    for (int k = 0; k < 12; k++) begin
      crk_s = 16'($urandom);
      step("rate");
      for (int i = 0; i < NCH; i++) if (upd[i]) ucnt[i]++;
    end
    chk("rate.ch0", 32'(ucnt[0]), 32'd12);
    chk("rate.ch1", 32'(ucnt[1]), 32'd6);
    chk("rate.ch2", 32'(ucnt[2]), 32'd4);
    chk("rate.ch3", 32'(ucnt[3]), 32'd3);

    // rst mid-sequence with pending skip counts.
    idle(); reset_nos = 1; div_cfg = 16'h3333;
    step("mid.init");
    reset_nos = 0; start_s = 4'hF; crk_s = 16'h9999;
    step("mid.a");
    step("mid.b");
    rst = 1;
    step("mid.rst");
    chk("mid.rst.s", 32'(s), 32'h0);
    chk("mid.rst.upd", 32'(upd), 32'h0);
    rst = 0; reset_nos = 1; start_s = '0;
    step("mid.reinit");
    reset_nos = 0; start_s = 4'hF; crk_s = 16'h7777;
    step("mid.first");
    chk("mid.first.upd", 32'(upd), 32'hF);
    chk("mid.first.s", 32'(s), 32'h7777);

    // Randomized run against the model.
    idle();
    for (int k = 0; k < 600; k++) begin
      rst       = ($urandom_range(0, 149) == 0);
      reset_nos = ($urandom_range(0, 29) == 0);
      start     = ($urandom_range(0, 3) != 0);
      start_s   = 4'($urandom);
      init_state = 4'($urandom);
      div_cfg   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'($urandom) & 16'h3333);
      crk_s     = ($urandom_range(0, 3) != 0) ? m_svec() : 16'($urandom);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
